// File: rtl/fp_pkg.sv
// Shared types and helpers for the iterative floating-point divider:
// FSM states, flag bit positions, exponent bias and operand classification.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Field helpers take the word zero-extended to 64 bits so one set of
  // functions serves every EXP_W/MAN_W combination.
  function automatic logic [63:0] exp_field(input logic [63:0] x, input int exp_w, input int man_w);
    return (x >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] man_field(input logic [63:0] x, input int man_w);
    return x & ((64'd1 << man_w) - 64'd1);
  endfunction

  function automatic logic is_nan(input logic [63:0] x, input int exp_w, input int man_w);
    return (exp_field(x, exp_w, man_w) == ((64'd1 << exp_w) - 64'd1)) && (man_field(x, man_w) != 64'd0);
  endfunction

  function automatic logic is_inf(input logic [63:0] x, input int exp_w, input int man_w);
    return (exp_field(x, exp_w, man_w) == ((64'd1 << exp_w) - 64'd1)) && (man_field(x, man_w) == 64'd0);
  endfunction

  function automatic logic is_zero(input logic [63:0] x, input int exp_w, input int man_w);
    return (exp_field(x, exp_w, man_w) == 64'd0) && (man_field(x, man_w) == 64'd0);
  endfunction

  function automatic logic is_sub(input logic [63:0] x, input int exp_w, input int man_w);
    return (exp_field(x, exp_w, man_w) == 64'd0) && (man_field(x, man_w) != 64'd0);
  endfunction

endpackage

// File: rtl/fp_mant_div_step.sv
// One radix-2 restoring division step: trial-subtract the divisor from the
// partial remainder, emit the quotient bit and the shifted next remainder.
module fp_mant_div_step
  import fp_pkg::*;
#(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W+1:0] rem_i,
  input  logic [MAN_W:0]   div_i,
  output logic [MAN_W+1:0] rem_o,
  output logic             q_o
);

  logic [MAN_W+1:0] div_ext;
  logic [MAN_W+1:0] diff;
  logic [MAN_W+1:0] kept;

  // Remainder stays below twice the divisor, so the shifted-out MSB is always 0.
  always_comb begin
    div_ext = {1'b0, div_i};
    diff    = rem_i - div_ext;
    q_o     = (rem_i >= div_ext);
    kept    = q_o ? diff : rem_i;
    rem_o   = {kept[MAN_W:0], 1'b0};
  end

endmodule

// File: rtl/fp_divider_iter.sv
// Multi-cycle floating-point divider: special-case classification at issue,
// one restoring quotient bit per clock, then a single round-to-nearest-even cycle.
module fp_divider_iter
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic [4:0]   flags
);

  localparam int ITER  = MAN_W + 3;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0]        LAST     = CNT_W'(ITER - 1);
  localparam logic signed [EXP_W+1:0] BIAS_S   = (EXP_W + 2)'(bias(EXP_W));
  localparam logic signed [EXP_W+1:0] EXP_MAX  = $signed({2'b00, {EXP_W{1'b1}}});
  localparam logic signed [EXP_W+1:0] EXP_ONE  = (EXP_W + 2)'(1);
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
  localparam logic [W-1:0]            QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] frac,
                                               input logic g, input logic r, input logic s);
    logic up;
    up = g & (r | s | frac[0]);
    return {1'b0, frac} + {{MAN_W{1'b0}}, up};
  endfunction

  function automatic logic [W-1:0] inf_word(input logic s);
    return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [W-1:0] zero_word(input logic s);
    return {s, {(W-1){1'b0}}};
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MAN_W+1:0]        rem_q, rem_d;
  logic [MAN_W:0]          div_q, div_d;
  logic [ITER-1:0]         quo_q, quo_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W+1:0] exp_q, exp_d;
  logic [W-1:0]            res_q, res_d;
  logic [4:0]              flags_q, flags_d;

  logic [MAN_W+1:0]        step_rem;
  logic                    step_bit;
  logic                    a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sgn;
  logic [MAN_W-1:0]        frac_pre;
  logic [MAN_W:0]          frac_rnd;
  logic                    g_bit, r_bit, s_bit;
  logic signed [EXP_W+1:0] exp_adj, exp_fin;

  fp_mant_div_step #(.MAN_W(MAN_W)) u_step (
    .rem_i (rem_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  // Subnormal operands are treated as zero (flush-to-zero).
  always_comb begin
    a_nan  = is_nan(64'(a), EXP_W, MAN_W);
    b_nan  = is_nan(64'(b), EXP_W, MAN_W);
    a_inf  = is_inf(64'(a), EXP_W, MAN_W);
    b_inf  = is_inf(64'(b), EXP_W, MAN_W);
    a_zero = is_zero(64'(a), EXP_W, MAN_W) | is_sub(64'(a), EXP_W, MAN_W);
    b_zero = is_zero(64'(b), EXP_W, MAN_W) | is_sub(64'(b), EXP_W, MAN_W);
    sgn    = a[W-1] ^ b[W-1];
  end

  // Normalise a quotient in [0.5,2) and pick guard/round/sticky for rounding.
  always_comb begin
    if (quo_q[ITER-1]) begin
      frac_pre = quo_q[ITER-2:2];
      g_bit    = quo_q[1];
      r_bit    = quo_q[0];
      exp_adj  = exp_q;
    end else begin
      frac_pre = quo_q[ITER-3:1];
      g_bit    = quo_q[0];
      r_bit    = 1'b0;
      exp_adj  = exp_q - EXP_ONE;
    end
    s_bit    = |rem_q;
    frac_rnd = round_rne(frac_pre, g_bit, r_bit, s_bit);
    exp_fin  = exp_adj + $signed({{(EXP_W+1){1'b0}}, frac_rnd[MAN_W]});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sgn;
          flags_d = '0;
          state_d = DONE;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res_d            = QNAN;
            flags_d[FLAG_NV] = 1'b1;
          end else if (b_zero && !a_inf) begin
            res_d            = inf_word(sgn);
            flags_d[FLAG_DZ] = 1'b1;
          end else if (a_inf) begin
            res_d = inf_word(sgn);
          end else if (b_inf || a_zero) begin
            res_d = zero_word(sgn);
          end else begin
            rem_d   = {1'b0, 1'b1, a[MAN_W-1:0]};
            div_d   = {1'b1, b[MAN_W-1:0]};
            quo_d   = '0;
            cnt_d   = '0;
            exp_d   = $signed({2'b00, a[W-2:MAN_W]}) - $signed({2'b00, b[W-2:MAN_W]}) + BIAS_S;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = {quo_q[ITER-2:0], step_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = ROUND;
      end
      ROUND: begin
        state_d          = DONE;
        flags_d          = '0;
        flags_d[FLAG_NX] = g_bit | r_bit | s_bit;
        if (exp_fin >= EXP_MAX) begin
          res_d            = inf_word(sign_q);
          flags_d[FLAG_OF] = 1'b1;
          flags_d[FLAG_NX] = 1'b1;
        end else if (exp_fin <= EXP_ZERO) begin
          res_d            = zero_word(sign_q);
          flags_d[FLAG_UF] = 1'b1;
          flags_d[FLAG_NX] = 1'b1;
        end else begin
          res_d = {sign_q, exp_fin[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = res_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_divider_iter.sv
// Scoreboard bench for fp_divider_iter: directed binary32 and binary16 vectors,
// back-pressure, and mid-division reset.
module tb_fp_divider_iter;

  typedef struct {
    logic [31:0] out;
    logic [4:0]  fl;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        iv32 = 1'b0, ir32, ov32, ordy32 = 1'b1;
  logic [31:0] a32 = '0, b32 = '0, o32;
  logic [4:0]  f32;
  logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, o16;
  logic [4:0]  f16;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q32[$];
  exp_t q16[$];
  bit          seen[2];
  bit          took[2];
  logic [31:0] hold_o[2];
  logic [4:0]  hold_f[2];

  fp_divider_iter dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(ordy32), .out(o32), .flags(f32)
  );

  fp_divider_iter #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(ordy16), .out(o16), .flags(f16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic mon(input int id, input logic ov, input logic ir, input logic ordy,
                     input logic [31:0] o, input logic [4:0] f);
    exp_t e;
    bit   empty;
    if (!rst_n) begin
      seen[id] = 1'b0;
      took[id] = 1'b0;
      return;
    end
    if (took[id]) begin
      chk(id == 0 ? "in_ready_after_take32" : "in_ready_after_take16", 32'(ir), 32'd1);
      took[id] = 1'b0;
    end
    if (ov && !seen[id]) begin
      seen[id]   = 1'b1;
      hold_o[id] = o;
      hold_f[id] = f;
      empty = (id == 0) ? (q32.size() == 0) : (q16.size() == 0);
      if (empty) begin
        total++;
        bad++;
        $display("FAIL unexpected_output dut%0d: got %h with nothing expected", id, o);
      end else begin
        if (id == 0) e = q32.pop_front();
        else         e = q16.pop_front();
        chk(id == 0 ? "out32" : "out16", o, e.out);
        chk(id == 0 ? "flags32" : "flags16", 32'(f), 32'(e.fl));
        chk(id == 0 ? "latency32" : "latency16", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end else if (ov) begin
      chk("hold_out", o, hold_o[id]);
      chk("hold_flags", 32'(f), 32'(hold_f[id]));
      chk("hold_in_ready", 32'(ir), 32'd0);
    end
    if (ov && ordy) begin
      seen[id] = 1'b0;
      took[id] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    mon(0, ov32, ir32, ordy32, o32, f32);
    mon(1, ov16, ir16, ordy16, {16'h0000, o16}, f16);
  end

  task automatic issue(input int id, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eo, input logic [4:0] ef, input int el, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    if (id == 0) begin a32 = av; b32 = bv; iv32 = 1'b1; end
    else begin a16 = av[15:0]; b16 = bv[15:0]; iv16 = 1'b1; end
    @(negedge clk);
    while (!(id == 0 ? ir32 : ir16) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL accept_timeout dut%0d: in_ready low for %0d cycles, want 1", id, n);
      iv32 = 1'b0;
      iv16 = 1'b0;
      return;
    end
    if (push) begin
      e.out = eo; e.fl = ef; e.lat = el; e.acc = cyc + 1;
      if (id == 0) q32.push_back(e);
      else         q16.push_back(e);
    end
    @(posedge clk); #1;
    iv32 = 1'b0;
    iv16 = 1'b0;
  endtask

  task automatic wait_out32(input int budget);
    int n;
    bit ir_seen;
    n = 0;
    ir_seen = 1'b0;
    do begin
      @(negedge clk); #1;
      if (!ov32 && ir32) ir_seen = 1'b1;
      n++;
    end while (!ov32 && n < budget);
    chk("busy_in_ready", 32'(ir_seen), 32'd0);
    if (!ov32) begin
      total++;
      bad++;
      $display("FAIL out_valid_timeout: out_valid still %0d after %0d cycles, want 1", ov32, n);
    end
  endtask

  task automatic wait_idle(input int id);
    int n;
    bit done;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
      done = (id == 0) ? (q32.size() == 0 && !ov32) : (q16.size() == 0 && !ov16);
    end while (!done && n < 500);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL idle_timeout dut%0d: still busy after %0d cycles, want idle", id, n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ir32), 32'd1);
    chk("rst_out_valid", 32'(ov32), 32'd0);
    chk("rst_out", o32, 32'h0);
    chk("rst_flags", 32'(f32), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;

    // Normal path, binary32
    issue(0, 32'h41460000, 32'h40A00000, 32'h401E6666, 5'b00001, 28, 1'b1);
    wait_out32(100);
    wait_idle(0);
    issue(0, 32'h41460000, 32'h40000000, 32'h40C60000, 5'b00000, 28, 1'b1); wait_idle(0);
    issue(0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28, 1'b1); wait_idle(0);
    issue(0, 32'hC0C00000, 32'h40400000, 32'hC0000000, 5'b00000, 28, 1'b1); wait_idle(0);

    // Special operands
    issue(0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1, 1'b1); wait_idle(0);
    issue(0, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1, 1'b1); wait_idle(0);
    issue(0, 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 1, 1'b1); wait_idle(0);
    issue(0, 32'h40000000, 32'hFF800000, 32'h80000000, 5'b00000, 1, 1'b1); wait_idle(0);
    issue(0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1, 1'b1); wait_idle(0);
    issue(0, 32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 1, 1'b1); wait_idle(0);

    // Range limits
    issue(0, 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 28, 1'b1); wait_idle(0);
    issue(0, 32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28, 1'b1); wait_idle(0);

    // Back-pressure then back-to-back issue
    @(posedge clk); #1 ordy32 = 1'b0;
    issue(0, 32'h40C00000, 32'h40400000, 32'h40000000, 5'b00000, 28, 1'b1);
    wait_out32(100);
    repeat (10) @(posedge clk);
    #1 ordy32 = 1'b1;
    issue(0, 32'h41460000, 32'h40000000, 32'h40C60000, 5'b00000, 28, 1'b1);
    wait_idle(0);

    // Reset in the middle of a division
    issue(0, 32'h41460000, 32'h40A00000, 32'h0, 5'b0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(ov32), 32'd0);
    chk("abort_in_ready", 32'(ir32), 32'd1);
    @(posedge clk); #3 rst_n = 1'b1;
    issue(0, 32'h40C00000, 32'h40400000, 32'h40000000, 5'b00000, 28, 1'b1); wait_idle(0);

    // binary16 instance
    issue(1, 32'h3C00, 32'h4200, 32'h3555, 5'b00001, 15, 1'b1); wait_idle(1);
    issue(1, 32'h4600, 32'h4200, 32'h4000, 5'b00000, 15, 1'b1); wait_idle(1);
    issue(1, 32'h3C00, 32'h0000, 32'h7C00, 5'b01000, 1, 1'b1);  wait_idle(1);
    issue(1, 32'h0000, 32'h0000, 32'h7E00, 5'b10000, 1, 1'b1);  wait_idle(1);
    issue(1, 32'hFC00, 32'h4000, 32'hFC00, 5'b00000, 1, 1'b1);  wait_idle(1);
    issue(1, 32'h7BFF, 32'h3800, 32'h7C00, 5'b00101, 15, 1'b1); wait_idle(1);
    issue(1, 32'h0400, 32'h4000, 32'h0000, 5'b00011, 15, 1'b1); wait_idle(1);

    repeat (3) @(negedge clk);
    #1;
    chk("leftover32", 32'(q32.size()), 32'd0);
    chk("leftover16", 32'(q16.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_divider_iter.md
Name: fp_divider_iter

Overview:
Parametrised, multi-cycle IEEE-754-style floating-point divider. It replaces the single-cycle combinational divider with a radix-2 restoring mantissa divider that produces one quotient bit per clock. Operand and result use valid/ready handshakes, so the block drops into the FPU datapath behind an operand issue stage and ahead of the writeback arbiter. Exponent and mantissa widths are generic, covering binary32 by default and binary16/bfloat16 by parameter.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (hidden bit excluded)
W, EXP_W+MAN_W+1, total word width (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
a  in  W  dividend {sign, exp, frac}
b  in  W  divisor
out_valid  out  1  result valid, held until taken
out_ready  in  1  consumer accepts result
out  out  W  quotient a/b
flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}; valid with out_valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out=0, flags=0, all datapath registers 0. Reset mid-division aborts the operation and produces no output.
- Accept: operands are accepted on a rising edge with in_valid&&in_ready. in_ready=1 only in IDLE. No pipelining; one operation in flight.
- Classify at acceptance; the result is chosen in priority order:
  - NaN in either operand, 0/0, or inf/inf -> canonical qNaN {0, all-ones exp, 1 followed by zeros}, invalid=1.
  - x/0 with x finite non-zero -> inf, sign = sa^sb, div_by_zero=1.
  - inf/finite -> inf. finite/inf -> signed zero. 0/finite -> signed zero.
- Special cases: IDLE->DONE. out_valid rises 1 cycle after acceptance.
- Subnormal inputs are flushed to signed zero before classification (FTZ). Subnormal results flush to signed zero with underflow=1 and inexact=1.
- Normal path: IDLE->DIV->ROUND->DONE.
  - DIV lasts ITER=MAN_W+3 cycles. Restoring division of {1,fa} by {1,fb} gives ITER quotient bits.
  - Sticky bit = OR of the final remainder.
  - exp_tmp = ea - eb + BIAS, computed signed at EXP_W+2 bits.
- ROUND (1 cycle):
  - If the quotient MSB is 0, shift left 1 and decrement exp_tmp.
  - Round-to-nearest-even using guard, round and sticky bits. A mantissa carry-out increments the exponent.
  - exp_tmp >= all-ones -> signed inf, overflow=1, inexact=1.
  - exp_tmp <= 0 -> signed zero, underflow=1, inexact=1.
  - inexact=1 whenever guard, round or sticky is non-zero.
- Normal latency: out_valid rises exactly ITER+2 cycles after the accept edge (binary32: 28).
- DONE: out and flags are stable while out_valid=1. When out_valid&&out_ready, go to IDLE and set in_ready=1 on the next cycle. out_ready held low stalls indefinitely with outputs held.
- out_ready while not out_valid is ignored.
- The result sign is always sa^sb, including zero and inf results; the NaN sign is always 0.

Decomposition:
- Package fp_pkg holds:
  - state enum (IDLE, DIV, ROUND, DONE)
  - flag bit index constants
  - BIAS function of EXP_W
  - functions is_nan, is_inf, is_zero, is_sub, parameterised by EXP_W/MAN_W
- One sub-module, fp_mant_div_step: combinational single restoring step (remainder, divisor -> next remainder, quotient bit). The FSM, counter and rounding stay in fp_divider_iter.

Test Plan:
- 0x41460000 (12.375) / 0x40A00000 (5.0) -> out=0x401E6666, flags=inexact only. out_valid exactly 28 cycles after accept, in_ready=0 throughout.
- 0x41460000 / 0x40000000 (2.0) -> 0x40C60000, flags=0. Then 0x3F800000 / 0x40400000 -> 0x3EAAAAAB (RNE rounds up), inexact=1.
- Specials, each with out_valid 1 cycle after accept:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1.
  - 0x00000000 / 0x00000000 -> 0x7FC00000, invalid=1.
  - 0xFF800000 / 0x40000000 -> 0xFF800000.
- Range: 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 with overflow and inexact. 0x00800000 / 0x40000000 -> 0x00000000 with underflow and inexact (FTZ).
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. out, flags and out_valid stay stable, in_ready stays 0. Release -> in_ready=1 the next cycle, and a back-to-back second operation is accepted.
- Reset: assert rst_n=0 at DIV cycle 10 -> out_valid=0 and in_ready=1 immediately. After release, a new 6.0/3.0 (0x40C00000/0x40400000) returns 0x40000000. Repeat the directed cases with EXP_W=5, MAN_W=10: 0x3C00/0x4200 -> 0x3555.
